// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write-side and uart-side signal bundle for uart_tx_fifo (overflow only with UART_TX_FIFO_OVF_STICKY_EN)
interface uart_tx_fifo_if #(
   parameter int AW = 4
);
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          ss;
   logic [7:0]    data;
   logic          busy;
`ifdef UART_TX_FIFO_OVF_STICKY_EN
   logic          overflow;

   modport slave  (input wr_en, wr_data, busy,
                   output full, empty, level, ss, data, overflow);
   modport master (output wr_en, wr_data, busy,
                   input full, empty, level, ss, data, overflow);
`else
   modport slave  (input wr_en, wr_data, busy,
                   output full, empty, level, ss, data);
   modport master (output wr_en, wr_data, busy,
                   input full, empty, level, ss, data);
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a uart transmitter via ss/busy handshake; optional sticky overflow with UART_TX_FIFO_OVF_STICKY_EN
module uart_tx_fifo #(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int ACK_WAIT = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   uart_tx_fifo_if.slave      io_bus
);

   localparam int CW = $clog2(ACK_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_cnt_nxt;

   logic [7:0]     r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_level;
   logic           r_ss;
   logic [7:0]     r_data;

   logic           w_full;
   logic           w_empty;
   logic           w_push;
   logic           w_pop;

   // Flags decode straight from the registered level, so they track the last edge.
   assign w_full  = (r_level == (AW+1)'(DEPTH));
   assign w_empty = (r_level == '0);
   // A push while full is dropped regardless of a simultaneous pop.
   assign w_push  = io_bus.wr_en && !w_full;

   // Launch/handshake sequencing and pop decision.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && !io_bus.busy) begin
               w_pop       = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (io_bus.busy) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_cnt == CW'(ACK_WAIT - 1)) begin
               // uart ignored the launch; give up so the queue keeps moving
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!io_bus.busy) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register and acknowledge-timeout counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= io_bus.wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**AW.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Launch strobe and byte to uart; data holds until the next launch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ss   <= 1'b0;
         r_data <= 8'h00;
      end else begin
         r_ss <= w_pop;
         if (w_pop) begin
            r_data <= r_mem[r_rd_ptr];
         end
      end
   end

   assign io_bus.full  = w_full;
   assign io_bus.empty = w_empty;
   assign io_bus.level = r_level;
   assign io_bus.ss    = r_ss;
   assign io_bus.data  = r_data;

`ifdef UART_TX_FIFO_OVF_STICKY_EN
   logic r_ovf;

   // Sticky flag set by any push dropped because the FIFO was full.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf <= 1'b0;
      end else if (io_bus.wr_en && w_full) begin
         r_ovf <= 1'b1;
      end
   end

   assign io_bus.overflow = r_ovf;
`else
   // No overflow tracking in this build.
`endif

endmodule
